fb_line_fetch: RTL and testbench

- Read-side engine for the bitmap framebuffer. It runs in the system clock domain and fetches one framebuffer row into the linebuffer at the start of each scaled display line.
- It drives the framebuffer BRAM read address and the linebuffer write strobe and address, accounting for the one-cycle BRAM read latency.
- It is the consumer of the pixels that the drawing path writes into the framebuffer.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_line_fetch.sv | 158 +++++++++++++++
 tb/tb_fb_line_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: fetch FSM state encoding and default geometry
// used by both the draw-side address calculation and the read-side line fetch.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } fb_state_t;

    localparam int FB_CORDW_DEF  = 16;
    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 180;
    localparam int FB_SCALE_DEF  = 2;
    localparam int FB_OFFY_DEF   = 60;

    // Wrapping counter of display lines within one framebuffer row.
    function automatic logic [5:0] scale_next(input logic [5:0] cnt, input logic [5:0] last);
        logic [5:0] nxt;
        if (cnt == last) begin
            nxt = 6'd0;
        end else begin
            nxt = cnt + 6'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fb_line_fetch.sv
// Framebuffer read engine: copies one framebuffer row into the linebuffer at the
// start of each scaled display line, compensating for one cycle of BRAM latency.
module fb_line_fetch
    import fb_pkg::*;
#(
    parameter int CORDW     = FB_CORDW_DEF,
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int FB_SCALE  = FB_SCALE_DEF,
    parameter int FB_OFFY   = FB_OFFY_DEF,
    parameter int ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT),
    parameter int LBAW      = $clog2(FB_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic signed [CORDW-1:0] sy,
    output logic                    fb_re,
    output logic [ADDRW-1:0]        fb_addr,
    output logic                    lb_we,
    output logic [LBAW-1:0]         lb_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int ROWW = $clog2(FB_HEIGHT + 1);

    localparam logic signed [CORDW-1:0] SY_FIRST   = CORDW'(FB_OFFY);
    localparam logic signed [CORDW-1:0] SY_END     = CORDW'(FB_OFFY + FB_HEIGHT * FB_SCALE);
    localparam logic [LBAW-1:0]         LAST_X     = LBAW'(FB_WIDTH - 1);
    localparam logic [ROWW-1:0]         LAST_ROW   = ROWW'(FB_HEIGHT - 1);
    localparam logic [5:0]              SCALE_LAST = 6'(FB_SCALE - 1);
    localparam logic [ADDRW-1:0]        ROW_STEP   = ADDRW'(FB_WIDTH);

    fb_state_t        state_r, state_s;
    logic [ADDRW-1:0] row_base_r, row_base_s;
    logic [ROWW-1:0]  row_r, row_s;
    logic [LBAW-1:0]  cnt_x_r, cnt_x_s;
    logic [5:0]       cnt_scale_r, cnt_scale_s;
    logic             overrun_s;
    logic             in_range_s;
    logic [ADDRW-1:0] fb_addr_s;

    // Signed compare keeps blanking lines (negative sy) out of range.
    assign in_range_s = (sy >= SY_FIRST) && (sy < SY_END);
    assign fb_addr_s  = row_base_s + ADDRW'(cnt_x_s);

    // Next-state and counter logic for the fetch FSM.
    always_comb begin
        state_s     = state_r;
        row_base_s  = row_base_r;
        row_s       = row_r;
        cnt_x_s     = cnt_x_r;
        cnt_scale_s = cnt_scale_r;
        overrun_s   = overrun;

        if (frame_start) begin
            row_base_s  = '0;
            row_s       = '0;
            cnt_x_s     = '0;
            cnt_scale_s = 6'd0;
            overrun_s   = 1'b0;
            state_s     = WAIT;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                WAIT: begin
                    if (line_start && in_range_s) begin
                        if (cnt_scale_r == 6'd0) begin
                            cnt_x_s = '0;
                            state_s = FETCH;
                        end else begin
                            state_s = WAIT;
                        end
                        cnt_scale_s = scale_next(cnt_scale_r, SCALE_LAST);
                    end else begin
                        state_s = WAIT;
                    end
                end
                FETCH: begin
                    // A line arriving mid-fetch is flagged and counted but never queued.
                    if (line_start) begin
                        overrun_s = 1'b1;
                        if (in_range_s) begin
                            cnt_scale_s = scale_next(cnt_scale_r, SCALE_LAST);
                        end else begin
                            cnt_scale_s = cnt_scale_r;
                        end
                    end else begin
                        overrun_s = overrun;
                    end
                    if (cnt_x_r == LAST_X) begin
                        cnt_x_s    = '0;
                        row_base_s = row_base_r + ROW_STEP;
                        row_s      = row_r + ROWW'(1);
                        if (row_r == LAST_ROW) begin
                            state_s = DONE;
                        end else begin
                            state_s = WAIT;
                        end
                    end else begin
                        cnt_x_s = cnt_x_r + LBAW'(1);
                        state_s = FETCH;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // FSM state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            row_base_r  <= '0;
            row_r       <= '0;
            cnt_x_r     <= '0;
            cnt_scale_r <= 6'd0;
        end else begin
            state_r     <= state_s;
            row_base_r  <= row_base_s;
            row_r       <= row_s;
            cnt_x_r     <= cnt_x_s;
            cnt_scale_r <= cnt_scale_s;
        end
    end

    // Registered outputs; the linebuffer strobe trails the read by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_re   <= 1'b0;
            fb_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            lb_we   <= 1'b0;
            lb_addr <= '0;
        end else begin
            fb_re   <= (state_s == FETCH);
            busy    <= (state_s == FETCH);
            fb_addr <= (state_s == FETCH) ? fb_addr_s : '0;
            done    <= (state_s == DONE);
            overrun <= overrun_s;
            lb_we   <= fb_re;
            lb_addr <= fb_re ? cnt_x_r : '0;
        end
    end

endmodule

// File: tb/tb_fb_line_fetch.sv
// Scoreboard bench for fb_line_fetch: a cycle-stamped model predicts reads,
// linebuffer writes and done pulses; a monitor compares them every cycle.
module tb_fb_line_fetch;

    localparam int W = 8, H = 4, SC = 2, OY = 2, CORDW = 16;
    localparam int ADDRW = $clog2(W * H);
    localparam int LBAW  = $clog2(W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic line_start = 1'b0;
    logic signed [CORDW-1:0] sy = '0;
    logic fb_re, lb_we, busy, done, overrun;
    logic [ADDRW-1:0] fb_addr;
    logic [LBAW-1:0]  lb_addr;

    fb_line_fetch #(
        .CORDW(CORDW), .FB_WIDTH(W), .FB_HEIGHT(H), .FB_SCALE(SC), .FB_OFFY(OY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
        .sy(sy), .fb_re(fb_re), .fb_addr(fb_addr), .lb_we(lb_we), .lb_addr(lb_addr),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int v;} ev_t;
    ev_t rdq[$];
    ev_t lbq[$];
    int  doneq[$];

    int n_chk = 0, n_fail = 0;

    // Model of the frame: rows fetched, line phase, sticky overrun, last fetch start edge.
    int m_row = 0, m_scale = 0, m_fs = -1000;
    bit m_active = 1'b0, m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rdq.delete(); lbq.delete(); doneq.delete();
        m_row = 0; m_scale = 0; m_fs = -1000; m_active = 1'b0; m_ovr = 1'b0;
    endtask

    // E is the clock edge on which the DUT samples the pulse; read k shows after edge E+k.
    task automatic model(input int e, input bit fs, input bit ls, input int syv);
        if (fs) begin
            while (rdq.size() > 0 && rdq[$].c >= e) void'(rdq.pop_back());
            while (doneq.size() > 0 && doneq[$] >= e) void'(doneq.pop_back());
            m_active = 1'b1; m_row = 0; m_scale = 0; m_ovr = 1'b0; m_fs = -1000;
        end else if (ls) begin
            bit inr;
            inr = (syv >= OY) && (syv < OY + H * SC);
            if (e >= m_fs + 1 && e <= m_fs + W) begin
                m_ovr = 1'b1;
                if (inr) m_scale = (m_scale + 1) % SC;
            end else if (m_active && inr) begin
                if (m_scale == 0) begin
                    for (int i = 0; i < W; i++) rdq.push_back('{e + i, m_row * W + i});
                    if (m_row == H - 1) begin
                        doneq.push_back(e + W);
                        m_active = 1'b0;
                    end
                    m_row++;
                    m_fs = e;
                end
                m_scale = (m_scale + 1) % SC;
            end
        end
    endtask

    task automatic pulse(input bit fs, input bit ls, input int syv);
        int e;
        @(negedge clk);
        e = cyc + 1;
        frame_start = fs; line_start = ls; sy = CORDW'(syv);
        model(e, fs, ls, syv);
        @(posedge clk);
        #1;
        frame_start = 1'b0; line_start = 1'b0;
        check("overrun", overrun, m_ovr);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fb_re"}, fb_re, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_lb_we"}, lb_we, 0);
        check({tag, "_lb_addr"}, lb_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // Monitor: every cycle the outputs must match whatever the queues hold for this cycle.
    always @(negedge clk) begin
        bit er, ew, ed;
        if (rst_n) begin
            er = rdq.size() > 0 && rdq[0].c == cyc;
            ew = lbq.size() > 0 && lbq[0].c == cyc;
            ed = doneq.size() > 0 && doneq[0] == cyc;
            check("fb_re", fb_re, er);
            check("busy", busy, er);
            if (er) begin
                check("fb_addr", fb_addr, rdq[0].v);
                lbq.push_back('{cyc + 1, rdq[0].v % W});
                void'(rdq.pop_front());
            end
            check("lb_we", lb_we, ew);
            if (ew) begin
                check("lb_addr", lb_addr, lbq[0].v);
                void'(lbq.pop_front());
            end
            check("done", done, ed);
            if (ed) void'(doneq.pop_front());
        end
    end

    initial begin
        // Reset state
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(3);

        // Asynchronous reset in the middle of a fetch
        pulse(1'b1, 1'b0, 0);
        pulse(1'b0, 1'b1, 2);
        idle(2);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        idle(10);

        // Nominal frame, then a stray line after done
        pulse(1'b1, 1'b0, 0);
        for (int s = 0; s <= 9; s++) begin
            idle(19);
            pulse(1'b0, 1'b1, s);
        end
        idle(19);
        pulse(1'b0, 1'b1, 4);
        check("post_done_busy", busy, 0);
        idle(15);

        // Overrun four cycles into a fetch, next row from addr 8
        pulse(1'b1, 1'b0, 0);
        pulse(1'b0, 1'b1, 2);
        idle(3);
        pulse(1'b0, 1'b1, 3);
        check("overrun_set", overrun, 1);
        idle(19);
        pulse(1'b0, 1'b1, 4);
        idle(19);
        pulse(1'b0, 1'b1, 5);
        idle(19);

        // Frame restart during the fetch of row 2
        pulse(1'b0, 1'b1, 6);
        idle(2);
        pulse(1'b1, 1'b0, 0);
        check("overrun_cleared", overrun, 0);
        idle(5);
        pulse(1'b0, 1'b1, 2);
        idle(19);

        // Simultaneous frame_start and line_start
        pulse(1'b1, 1'b1, 2);
        idle(19);
        pulse(1'b0, 1'b1, 2);
        idle(19);

        // Randomised frames with variable line spacing and occasional restarts
        for (int f = 0; f < 6; f++) begin
            pulse(1'b1, 1'b0, 0);
            for (int s = -3; s <= 12; s++) begin
                idle($urandom_range(0, 12));
                if ($urandom_range(0, 15) == 0) pulse(1'b1, 1'($urandom_range(0, 1)), s);
                else pulse(1'b0, 1'b1, s);
            end
            idle(30);
        end

        check("reads_drained", rdq.size(), 0);
        check("lb_drained", lbq.size(), 0);
        check("done_drained", doneq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
